// File: rtl/riscv_wb_pkg.sv
// riscv_wb_pkg: shared entry type, source select and default sizes for the
// write-back arbiter and its long-latency FIFO.
package riscv_wb_pkg;

    localparam int unsigned WB_WIDTH        = 32;
    localparam int unsigned WB_ADDR         = 5;
    localparam int unsigned WB_DEPTH        = 4;
    localparam int unsigned WB_STARVE_LIMIT = 8;

    // One buffered long-latency result.
    typedef struct packed {
        logic [WB_ADDR-1:0]  rd;
        logic [WB_WIDTH-1:0] data;
    } wb_entry_t;

    // Which source feeds the output stage this cycle.
    typedef enum logic [1:0] {
        SrcNone = 2'd0,
        SrcAlu  = 2'd1,
        SrcFifo = 2'd2
    } wb_src_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: ALU and long-latency result inputs, regfile write port
// and scoreboard outputs of the write-back arbiter.
// Optional macro WB_BYPASS_EN adds the operand bypass lookup signals.
interface regfile_wb_arbiter_if
    import riscv_wb_pkg::*;
#(
    parameter int unsigned WIDTH = WB_WIDTH,
    parameter int unsigned ADDR  = WB_ADDR,
    parameter int unsigned DEPTH = WB_DEPTH
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic               alu_valid;
    logic [ADDR-1:0]    alu_rd;
    logic [WIDTH-1:0]   alu_data;
    logic               alu_stall;
    logic               mem_valid;
    logic               mem_ready;
    logic [ADDR-1:0]    mem_rd;
    logic [WIDTH-1:0]   mem_data;
    logic               wr_en;
    logic [ADDR-1:0]    wr_rd;
    logic [WIDTH-1:0]   wr_data;
    logic [2**ADDR-1:0] busy_mask;
    logic [CW-1:0]      fifo_count;
`ifdef WB_BYPASS_EN
    logic [ADDR-1:0]    byp_rs1;
    logic [ADDR-1:0]    byp_rs2;
    logic               byp_hit1;
    logic               byp_hit2;
    logic [WIDTH-1:0]   byp_data1;
    logic [WIDTH-1:0]   byp_data2;

    modport master (
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, byp_rs1, byp_rs2,
        input  alu_stall, mem_ready, wr_en, wr_rd, wr_data, busy_mask, fifo_count,
        input  byp_hit1, byp_hit2, byp_data1, byp_data2
    );
    modport slave (
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, byp_rs1, byp_rs2,
        output alu_stall, mem_ready, wr_en, wr_rd, wr_data, busy_mask, fifo_count,
        output byp_hit1, byp_hit2, byp_data1, byp_data2
    );
`else
    modport master (
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        input  alu_stall, mem_ready, wr_en, wr_rd, wr_data, busy_mask, fifo_count
    );
    modport slave (
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        output alu_stall, mem_ready, wr_en, wr_rd, wr_data, busy_mask, fifo_count
    );
`endif

endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: in-order DEPTH-entry FIFO of wb_entry_t for long-latency results.
// Exposes occupancy plus an age-ordered view (index 0 = head) of every slot so the
// arbiter can build the pending-write mask and, with WB_BYPASS_EN, search for data.
module wb_fifo
    import riscv_wb_pkg::*;
#(
    parameter int unsigned DEPTH = WB_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  wb_entry_t                  i_entry,
    input  logic                       i_pop,
`ifdef WB_BYPASS_EN
    output logic [WB_WIDTH-1:0]        o_data [DEPTH],
`endif
    output wb_entry_t                  o_head,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_empty,
    output logic [DEPTH-1:0]           o_valid,
    output logic [WB_ADDR-1:0]         o_rd [DEPTH]
);
    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned PW = IW + 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    wb_entry_t     r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] w_count;
    logic          w_full;
    logic          w_push;
    logic          w_pop;

    // Extra pointer MSB tells full from empty when the slot indices match.
    assign w_full  = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                     (r_wr_ptr[IW-1:0] == r_rd_ptr[IW-1:0]);
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign w_count = r_wr_ptr - r_rd_ptr;
    assign o_count = CW'(w_count);
    assign w_push  = i_push && !w_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_head  = r_mem[r_rd_ptr[IW-1:0]];

    // Pointer update; reset drops every buffered entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Entry storage; stale slots are unreachable once the pointers move.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[IW-1:0]] <= i_entry;
    end

    // Age-ordered view of all slots, valid only below the current occupancy.
    always_comb begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
            logic [PW-1:0] idx;
            idx        = r_rd_ptr + PW'(k);
            o_valid[k] = (PW'(k) < w_count);
            o_rd[k]    = r_mem[idx[IW-1:0]].rd;
`ifdef WB_BYPASS_EN
            o_data[k]  = r_mem[idx[IW-1:0]].data;
`endif
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: owns the regfile write port. Single-cycle ALU results win by
// default; long-latency results are buffered in wb_fifo and drained whenever the ALU
// is idle, or forcibly after STARVE_LIMIT consecutive ALU wins via a one-cycle stall.
// Optional macro WB_BYPASS_EN adds a combinational operand bypass lookup.
// WIDTH/ADDR must match the riscv_wb_pkg widths that size wb_entry_t.
module regfile_wb_arbiter
    import riscv_wb_pkg::*;
#(
    parameter int unsigned WIDTH        = WB_WIDTH,
    parameter int unsigned ADDR         = WB_ADDR,
    parameter int unsigned DEPTH        = WB_DEPTH,
    parameter int unsigned STARVE_LIMIT = WB_STARVE_LIMIT
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int unsigned NREG = 2 ** ADDR;
    localparam int unsigned CW   = $clog2(DEPTH + 1);
    localparam int unsigned SW   = $clog2(STARVE_LIMIT + 1);

    wb_entry_t          w_head;
    wb_entry_t          w_push_entry;
    logic [CW-1:0]      w_count;
    logic               w_empty;
    logic [DEPTH-1:0]   w_valid;
    logic [ADDR-1:0]    w_rd [DEPTH];
    logic               w_push;
    logic               w_pop;
    logic               w_stall_set;
    wb_src_t            w_src;
    logic [NREG-1:0]    w_fifo_busy;
    logic [NREG-1:0]    w_busy;

    logic               r_wr_en;
    logic [ADDR-1:0]    r_wr_rd;
    logic [WIDTH-1:0]   r_wr_data;
    logic               r_alu_stall;
    logic [SW-1:0]      r_starve;

`ifdef WB_BYPASS_EN
    logic [WIDTH-1:0]   w_data [DEPTH];
`endif

    // Occupancy is registered, so a pop in the same cycle never frees a slot early.
    assign bus.mem_ready = !reset && (w_count < CW'(DEPTH));
    // Writes to x0 complete the handshake but are never buffered.
    assign w_push        = bus.mem_valid && bus.mem_ready && (bus.mem_rd != '0);
    assign w_push_entry  = '{rd: bus.mem_rd, data: bus.mem_data};

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_entry (w_push_entry),
        .i_pop   (w_pop),
`ifdef WB_BYPASS_EN
        .o_data  (w_data),
`endif
        .o_head  (w_head),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_valid (w_valid),
        .o_rd    (w_rd)
    );

    // Source select: forced drain on stall, else ALU, else FIFO head.
    always_comb begin
        w_src = SrcNone;
        if (r_alu_stall && !w_empty) begin
            w_src = SrcFifo;
        end else if (bus.alu_valid && (bus.alu_rd != '0) && !r_alu_stall) begin
            w_src = SrcAlu;
        end else if (!w_empty) begin
            w_src = SrcFifo;
        end
        w_pop       = (w_src == SrcFifo);
        w_stall_set = (w_src == SrcAlu) && !w_empty && (r_starve == SW'(STARVE_LIMIT - 1));
    end

    // Output stage; wr_rd/wr_data hold their last value on idle cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_en   <= 1'b0;
            r_wr_rd   <= '0;
            r_wr_data <= '0;
        end else begin
            case (w_src)
                SrcAlu: begin
                    r_wr_en   <= 1'b1;
                    r_wr_rd   <= bus.alu_rd;
                    r_wr_data <= bus.alu_data;
                end
                SrcFifo: begin
                    r_wr_en   <= 1'b1;
                    r_wr_rd   <= w_head.rd;
                    r_wr_data <= w_head.data;
                end
                default: r_wr_en <= 1'b0;
            endcase
        end
    end

    // Starvation tracking: count ALU wins over a waiting FIFO, stall once at the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve    <= '0;
            r_alu_stall <= 1'b0;
        end else begin
            r_alu_stall <= w_stall_set;
            if (w_empty || w_pop) begin
                r_starve <= '0;
            end else if (w_src == SrcAlu) begin
                r_starve <= r_starve + 1'b1;
            end
        end
    end

    // Pending-write mask over buffered entries and the output stage; x0 never pending.
    always_comb begin
        w_fifo_busy = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (w_valid[k]) w_fifo_busy[w_rd[k]] = 1'b1;
        end
        w_busy = w_fifo_busy;
        if (r_wr_en) w_busy[r_wr_rd] = 1'b1;
        w_busy[0] = 1'b0;
    end

    assign bus.busy_mask  = w_busy;
    assign bus.fifo_count = w_count;
    assign bus.wr_en      = r_wr_en;
    assign bus.wr_rd      = r_wr_rd;
    assign bus.wr_data    = r_wr_data;
    assign bus.alu_stall  = r_alu_stall;

`ifdef WB_BYPASS_EN
    // Youngest matching source wins: FIFO entries are younger than the output stage.
    function automatic logic [WIDTH:0] byp_lookup(input logic [ADDR-1:0] rs);
        logic [WIDTH:0] res;
        res = '0;
        if (rs != '0) begin
            if (r_wr_en && (r_wr_rd == rs)) res = {1'b1, r_wr_data};
            for (int unsigned k = 0; k < DEPTH; k++) begin
                if (w_valid[k] && (w_rd[k] == rs)) res = {1'b1, w_data[k]};
            end
        end
        return res;
    endfunction

    assign {bus.byp_hit1, bus.byp_data1} = byp_lookup(bus.byp_rs1);
    assign {bus.byp_hit2, bus.byp_data2} = byp_lookup(bus.byp_rs2);
`endif

    // ALU result offered during the forced drain is dropped; upstream must hold off.
    a_no_alu_during_stall : assert property (@(posedge clk) disable iff (reset)
        !(bus.alu_valid && r_alu_stall));

    // An ALU write must not overtake a buffered write to the same register. The output
    // stage is excluded: it commits before any newly presented write can.
    a_no_waw_overtake : assert property (@(posedge clk) disable iff (reset)
        !(bus.alu_valid && (bus.alu_rd != '0) && w_fifo_busy[bus.alu_rd]));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed scenarios with hand-computed expectations.
module tb_regfile_wb_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.WIDTH(32), .ADDR(5), .DEPTH(4)) bus ();

    regfile_wb_arbiter #(
        .WIDTH        (32),
        .ADDR         (5),
        .DEPTH        (4),
        .STARVE_LIMIT (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alu_valid = 1'b0;
        bus.alu_rd    = '0;
        bus.alu_data  = '0;
        bus.mem_valid = 1'b0;
        bus.mem_rd    = '0;
        bus.mem_data  = '0;
`ifdef WB_BYPASS_EN
        bus.byp_rs1   = '0;
        bus.byp_rs2   = '0;
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.mem_valid = 1'b1;
        bus.mem_rd    = 5'd3;
        bus.mem_data  = 32'h0000_0033;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL rst_wr_en got=%0h exp=0", bus.wr_en); end
            total++; if (bus.mem_ready !== 1'b0) begin bad++; $display("FAIL rst_mem_ready got=%0h exp=0", bus.mem_ready); end
            total++; if (bus.fifo_count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", bus.fifo_count); end
            total++; if (bus.busy_mask !== 32'h0) begin bad++; $display("FAIL rst_busy got=%h exp=0", bus.busy_mask); end
        end
        total++; if (bus.wr_rd !== 5'd0) begin bad++; $display("FAIL rst_wr_rd got=%0d exp=0", bus.wr_rd); end
        total++; if (bus.wr_data !== 32'h0) begin bad++; $display("FAIL rst_wr_data got=%h exp=0", bus.wr_data); end
        total++; if (bus.alu_stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%0h exp=0", bus.alu_stall); end
        reset = 1'b0;
        bus.mem_valid = 1'b0;
        #1;
        total++; if (bus.mem_ready !== 1'b1) begin bad++; $display("FAIL rel_mem_ready got=%0h exp=1", bus.mem_ready); end
    endtask

    task automatic test_alu_only();
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd5;
        bus.alu_data  = 32'hDEAD_BEEF;
        tick();
        total++; if (bus.wr_en !== 1'b1) begin bad++; $display("FAIL alu_wr_en got=%0h exp=1", bus.wr_en); end
        total++; if (bus.wr_rd !== 5'd5) begin bad++; $display("FAIL alu_wr_rd got=%0d exp=5", bus.wr_rd); end
        total++; if (bus.wr_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL alu_wr_data got=%h exp=deadbeef", bus.wr_data); end
        total++; if (bus.busy_mask !== 32'h0000_0020) begin bad++; $display("FAIL alu_busy got=%h exp=00000020", bus.busy_mask); end
        bus.alu_valid = 1'b0;
        tick();
        total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL alu_idle_wr_en got=%0h exp=0", bus.wr_en); end
        total++; if (bus.wr_rd !== 5'd5) begin bad++; $display("FAIL alu_hold_rd got=%0d exp=5", bus.wr_rd); end
        total++; if (bus.wr_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL alu_hold_data got=%h exp=deadbeef", bus.wr_data); end
        total++; if (bus.busy_mask !== 32'h0) begin bad++; $display("FAIL alu_idle_busy got=%h exp=0", bus.busy_mask); end
    endtask

    task automatic test_x0();
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd0;
        bus.alu_data  = 32'h0000_0055;
        bus.mem_valid = 1'b1;
        bus.mem_rd    = 5'd0;
        bus.mem_data  = 32'h0000_1234;
        #1;
        total++; if (bus.mem_ready !== 1'b1) begin bad++; $display("FAIL x0_handshake got=%0h exp=1", bus.mem_ready); end
        tick();
        idle_inputs();
        total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL x0_wr_en got=%0h exp=0", bus.wr_en); end
        total++; if (bus.fifo_count !== 3'd0) begin bad++; $display("FAIL x0_count got=%0d exp=0", bus.fifo_count); end
        tick();
        total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL x0_late_wr_en got=%0h exp=0", bus.wr_en); end
    endtask

    task automatic test_mem_latency();
        bus.mem_valid = 1'b1;
        bus.mem_rd    = 5'd3;
        bus.mem_data  = 32'h0000_0ABC;
        tick();
        bus.mem_valid = 1'b0;
        total++; if (bus.fifo_count !== 3'd1) begin bad++; $display("FAIL lat_count got=%0d exp=1", bus.fifo_count); end
        total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL lat_early_wr got=%0h exp=0", bus.wr_en); end
        total++; if (bus.busy_mask !== 32'h0000_0008) begin bad++; $display("FAIL lat_busy_q got=%h exp=00000008", bus.busy_mask); end
        tick();
        total++; if (bus.wr_en !== 1'b1 || bus.wr_rd !== 5'd3) begin bad++; $display("FAIL lat_write got=%0h/%0d exp=1/3", bus.wr_en, bus.wr_rd); end
        total++; if (bus.wr_data !== 32'h0000_0ABC) begin bad++; $display("FAIL lat_data got=%h exp=00000abc", bus.wr_data); end
        total++; if (bus.busy_mask !== 32'h0000_0008) begin bad++; $display("FAIL lat_busy_out got=%h exp=00000008", bus.busy_mask); end
        tick();
        total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL lat_done got=%0h exp=0", bus.wr_en); end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
        for (int i = 0; i < 3; i++) begin
            exp_rd   = 5'(6 + i);
            exp_data = 32'hCAFE_0000 + 32'(i);
            bus.alu_valid = 1'b1;
            bus.alu_rd    = exp_rd;
            bus.alu_data  = exp_data;
            tick();
            total++; if (bus.wr_en !== 1'b1 || bus.wr_rd !== exp_rd || bus.wr_data !== exp_data) begin
                bad++; $display("FAIL b2b_%0d got=%0h/%0d/%h exp=1/%0d/%h", i, bus.wr_en, bus.wr_rd, bus.wr_data, exp_rd, exp_data);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            bus.alu_valid = 1'b1;
            bus.alu_rd    = 5'(20 + i);
            bus.alu_data  = 32'h0000_0200 + 32'(i);
            bus.mem_valid = 1'b1;
            bus.mem_rd    = 5'(i + 1);
            bus.mem_data  = 32'h0000_0100 + 32'(i);
            total++; if (bus.mem_ready !== 1'b1) begin bad++; $display("FAIL full_ready_%0d got=%0h exp=1", i, bus.mem_ready); end
            tick();
        end
        total++; if (bus.fifo_count !== 3'd4) begin bad++; $display("FAIL full_count got=%0d exp=4", bus.fifo_count); end
        total++; if (bus.mem_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%0h exp=0", bus.mem_ready); end
        total++; if (bus.busy_mask !== 32'h0080_001E) begin bad++; $display("FAIL full_busy got=%h exp=0080001e", bus.busy_mask); end
        total++; if (bus.wr_rd !== 5'd23) begin bad++; $display("FAIL full_alu_rd got=%0d exp=23", bus.wr_rd); end
        // Release the ALU; offer a push while full, which must be refused.
        bus.alu_valid = 1'b0;
        bus.mem_valid = 1'b1;
        bus.mem_rd    = 5'd9;
        bus.mem_data  = 32'h0000_0999;
        for (int i = 0; i < 4; i++) begin
            tick();
            bus.mem_valid = 1'b0;
            total++; if (bus.wr_en !== 1'b1 || bus.wr_rd !== 5'(i + 1) || bus.wr_data !== 32'h0000_0100 + 32'(i)) begin
                bad++; $display("FAIL drain_%0d got=%0h/%0d/%h exp=1/%0d/%h", i, bus.wr_en, bus.wr_rd, bus.wr_data, i + 1, 32'h100 + i);
            end
            if (i == 0) begin
                total++; if (bus.fifo_count !== 3'd3) begin bad++; $display("FAIL full_no_push got=%0d exp=3", bus.fifo_count); end
            end
        end
        tick();
        total++; if (bus.wr_en !== 1'b0 || bus.fifo_count !== 3'd0) begin
            bad++; $display("FAIL drain_end got=%0h/%0d exp=0/0", bus.wr_en, bus.fifo_count);
        end
    endtask

    task automatic test_starve();
        bus.mem_valid = 1'b1;
        bus.mem_rd    = 5'd7;
        bus.mem_data  = 32'h0000_0077;
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd10;
        bus.alu_data  = 32'h0000_00A0;
        tick();
        bus.mem_valid = 1'b0;
        total++; if (bus.fifo_count !== 3'd1 || bus.alu_stall !== 1'b0) begin
            bad++; $display("FAIL starve_setup got=%0d/%0h exp=1/0", bus.fifo_count, bus.alu_stall);
        end
        for (int i = 1; i <= 8; i++) begin
            bus.alu_data = 32'h0000_00A0 + 32'(i);
            tick();
            total++; if (bus.alu_stall !== (i == 8)) begin bad++; $display("FAIL starve_win_%0d got=%0h exp=%0h", i, bus.alu_stall, (i == 8)); end
        end
        total++; if (bus.wr_rd !== 5'd10 || bus.fifo_count !== 3'd1) begin
            bad++; $display("FAIL starve_alu got=%0d/%0d exp=10/1", bus.wr_rd, bus.fifo_count);
        end
        bus.alu_valid = 1'b0;
        tick();
        total++; if (bus.wr_en !== 1'b1 || bus.wr_rd !== 5'd7 || bus.wr_data !== 32'h0000_0077) begin
            bad++; $display("FAIL starve_pop got=%0h/%0d/%h exp=1/7/00000077", bus.wr_en, bus.wr_rd, bus.wr_data);
        end
        total++; if (bus.alu_stall !== 1'b0 || bus.fifo_count !== 3'd0) begin
            bad++; $display("FAIL starve_clear got=%0h/%0d exp=0/0", bus.alu_stall, bus.fifo_count);
        end
        tick();
    endtask

    task automatic test_reset_midop();
        int pulses;
        for (int i = 0; i < 3; i++) begin
            bus.alu_valid = 1'b1;
            bus.alu_rd    = 5'(20 + i);
            bus.alu_data  = 32'h0000_0300 + 32'(i);
            bus.mem_valid = 1'b1;
            bus.mem_rd    = 5'(11 + i);
            bus.mem_data  = 32'h0000_0400 + 32'(i);
            tick();
        end
        idle_inputs();
        total++; if (bus.fifo_count !== 3'd3) begin bad++; $display("FAIL mid_count got=%0d exp=3", bus.fifo_count); end
        reset = 1'b1;
        tick();
        total++; if (bus.fifo_count !== 3'd0 || bus.busy_mask !== 32'h0) begin
            bad++; $display("FAIL mid_rst got=%0d/%h exp=0/0", bus.fifo_count, bus.busy_mask);
        end
        total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL mid_rst_wr got=%0h exp=0", bus.wr_en); end
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.wr_en === 1'b1) pulses++;
        end
        total++; if (pulses != 0) begin bad++; $display("FAIL mid_stale got=%0d exp=0", pulses); end
    endtask

`ifdef WB_BYPASS_EN
    task automatic test_bypass();
        for (int i = 0; i < 2; i++) begin
            bus.alu_valid = 1'b1;
            bus.alu_rd    = 5'd12;
            bus.alu_data  = 32'h0000_00C0 + 32'(i);
            bus.mem_valid = 1'b1;
            bus.mem_rd    = 5'd9;
            bus.mem_data  = (i == 0) ? 32'h0000_0011 : 32'h0000_0022;
            tick();
        end
        bus.mem_valid = 1'b0;
        bus.byp_rs1   = 5'd9;
        bus.byp_rs2   = 5'd0;
        #1;
        total++; if (bus.byp_hit1 !== 1'b1 || bus.byp_data1 !== 32'h0000_0022) begin
            bad++; $display("FAIL byp_young got=%0h/%h exp=1/00000022", bus.byp_hit1, bus.byp_data1);
        end
        total++; if (bus.byp_hit2 !== 1'b0 || bus.byp_data2 !== 32'h0) begin
            bad++; $display("FAIL byp_x0 got=%0h/%h exp=0/0", bus.byp_hit2, bus.byp_data2);
        end
        bus.byp_rs2 = 5'd12;
        #1;
        total++; if (bus.byp_hit2 !== 1'b1 || bus.byp_data2 !== 32'h0000_00C1) begin
            bad++; $display("FAIL byp_out got=%0h/%h exp=1/000000c1", bus.byp_hit2, bus.byp_data2);
        end
        idle_inputs();
        for (int i = 0; i < 4; i++) tick();
    endtask
`endif

    initial begin
        idle_inputs();
        test_reset();
        test_alu_only();
        test_x0();
        test_mem_latency();
        test_back_to_back();
        test_full();
        test_starve();
        test_reset_midop();
`ifdef WB_BYPASS_EN
        test_bypass();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
